// File: rtl/dmem_responder.sv
// Data-memory responder for the LEGv8 datapath: one request at a time over a
// valid/ready handshake, programmable latency, 64-bit doubleword read or write.
module dmem_responder #(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [63:0] r_rdata;
   logic        r_err;
   logic [63:0] r_mem [DEPTH];

   logic [60:0]      w_index;
   logic             w_err;
   logic [IDX_W-1:0] w_slot;

   // The range test uses all 61 index bits so a huge address can never alias
   // onto a small slot; w_slot is only used once the access is known legal.
   assign w_index = r_addr[63:3];
   assign w_err   = (r_addr[2:0] != 3'd0) || (w_index >= 61'(DEPTH));
   assign w_slot  = w_index[IDX_W-1:0];

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   // NOTE: storage is a flop array, not a RAM macro, because every entry must
   // clear on reset; a RAM could not be reset in a single asynchronous event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write     <= req_write;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_cnt       <= 4'(LATENCY - 1);
                  r_req_ready <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_err        <= w_err;
                  if (w_err || r_write) begin
                     r_rdata <= '0;
                  end else begin
                     r_rdata <= r_mem[w_slot];
                  end
                  if (!w_err && r_write) begin
                     r_mem[w_slot] <= r_wdata;
                  end
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2, 3, 1),
// directed vector table, reset/back-to-back sequences and a random phase.
module tb_dmem_responder;

   localparam int DEPTH = 32;
   localparam int N_INST = 3;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : (k == 1) ? 3 : 1;
   endfunction

   logic        clk;
   logic        rst          [N_INST];
   logic        req_valid    [N_INST];
   logic        req_ready    [N_INST];
   logic        req_write    [N_INST];
   logic [63:0] req_addr     [N_INST];
   logic [63:0] req_wdata    [N_INST];
   logic        resp_valid   [N_INST];
   logic        resp_ready   [N_INST];
   logic [63:0] resp_rdata   [N_INST];
   logic        resp_err     [N_INST];

   for (genvar g = 0; g < N_INST; g++) begin : g_dut
      dmem_responder #(.DEPTH(DEPTH), .LATENCY(lat_of(g))) u_dut (
         .clk        (clk),
         .reset      (rst[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_write  (req_write[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Reference memory: a doubleword array per instance, addressed by byte/8.
   logic [63:0] model_mem [N_INST][DEPTH];

   task automatic model_access(input int k, input logic wr, input logic [63:0] addr,
                               input logic [63:0] wd, output logic [63:0] rd, output logic err);
      int idx;
      if ((addr % 64'd8) != 64'd0 || (addr / 64'd8) >= 64'(DEPTH)) begin
         rd  = '0;
         err = 1'b1;
      end else begin
         idx = int'(addr / 64'd8);
         err = 1'b0;
         if (wr) begin
            model_mem[k][idx] = wd;
            rd = '0;
         end else begin
            rd = model_mem[k][idx];
         end
      end
   endtask

   // Full transaction; entered and left just after a falling edge.
   task automatic txn(input int k, input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                      input int stall, input logic poke, input logic [63:0] exp_rd,
                      input logic exp_err, input string tag, output int acc_cyc);
      int n;
      acc_cyc = 0;
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (req_ready[k] !== 1'b1) begin
         timeout({tag, " req_ready"});
         return;
      end
      req_valid[k]  = 1'b1;
      req_write[k]  = wr;
      req_addr[k]   = addr;
      req_wdata[k]  = wd;
      resp_ready[k] = (stall == 0);
      @(negedge clk);
      acc_cyc      = cyc;
      req_valid[k] = 1'b0;
      check({tag, " busy_after_accept"}, 64'(req_ready[k]), 64'd0);
      n = 0;
      while (resp_valid[k] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (resp_valid[k] !== 1'b1) begin
         timeout({tag, " resp_valid"});
         resp_ready[k] = 1'b1;
         return;
      end
      check({tag, " latency"}, 64'(n), 64'(lat_of(k)));
      check({tag, " rdata"}, resp_rdata[k], exp_rd);
      check({tag, " err"}, 64'(resp_err[k]), 64'(exp_err));
      for (int s = 0; s < stall; s++) begin
         if (poke) begin
            req_valid[k] = 1'b1;
            req_write[k] = 1'b1;
            req_addr[k]  = 64'h0;
            req_wdata[k] = '1;
         end
         @(negedge clk);
         check($sformatf("%s stall%0d valid", tag, s), 64'(resp_valid[k]), 64'd1);
         check($sformatf("%s stall%0d rdata", tag, s), resp_rdata[k], exp_rd);
         check($sformatf("%s stall%0d err", tag, s), 64'(resp_err[k]), 64'(exp_err));
         check($sformatf("%s stall%0d req_ready", tag, s), 64'(req_ready[k]), 64'd0);
      end
      req_valid[k]  = 1'b0;
      resp_ready[k] = 1'b1;
      @(negedge clk);
      check({tag, " resp_done"}, 64'(resp_valid[k]), 64'd0);
      check({tag, " ready_again"}, 64'(req_ready[k]), 64'd1);
   endtask

   typedef struct {
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wd;
      int          stall;
      logic        poke;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int N_VEC = 15;
   vec_t vecs [N_VEC];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] m_rd;
      logic        m_err;
      logic [63:0] addr;
      int          acc;
      int          prev_acc;

      vecs[0]  = '{1'b0, 64'h0,                   64'h0,                   0, 1'b0, 64'h0,                   1'b0};
      vecs[1]  = '{1'b1, 64'h18,                  64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0, 64'h0,                   1'b0};
      vecs[2]  = '{1'b0, 64'h18,                  64'h0,                   0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
      vecs[3]  = '{1'b0, 64'h1C,                  64'h0,                   1, 1'b0, 64'h0,                   1'b1};
      vecs[4]  = '{1'b1, 64'h100,                 64'h55,                  0, 1'b0, 64'h0,                   1'b1};
      vecs[5]  = '{1'b0, 64'h100,                 64'h0,                   0, 1'b0, 64'h0,                   1'b1};
      vecs[6]  = '{1'b0, 64'h0,                   64'h0,                   0, 1'b0, 64'h0,                   1'b0};
      vecs[7]  = '{1'b0, 64'h18,                  64'h0,                   5, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
      vecs[8]  = '{1'b0, 64'h0,                   64'h0,                   0, 1'b0, 64'h0,                   1'b0};
      vecs[9]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                   0, 1'b0, 64'h0,                   1'b1};
      vecs[10] = '{1'b1, 64'h8000_0000_0000_0018, 64'h99,                  0, 1'b0, 64'h0,                   1'b1};
      vecs[11] = '{1'b1, 64'h0100_0000_0000_0018, 64'h77,                  0, 1'b0, 64'h0,                   1'b1};
      vecs[12] = '{1'b0, 64'h18,                  64'h0,                   0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
      vecs[13] = '{1'b1, 64'hF8,                  64'h1234,                2, 1'b0, 64'h0,                   1'b0};
      vecs[14] = '{1'b0, 64'hF8,                  64'h0,                   0, 1'b0, 64'h1234,                1'b0};

      for (int k = 0; k < N_INST; k++) begin
         rst[k]        = 1'b0;
         req_valid[k]  = 1'b0;
         req_write[k]  = 1'b0;
         req_addr[k]   = '0;
         req_wdata[k]  = '0;
         resp_ready[k] = 1'b0;
         for (int i = 0; i < DEPTH; i++) model_mem[k][i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < N_INST; k++) rst[k] = 1'b1;
      @(negedge clk);

      // Park instance 0 in RESP with an error, then reset asynchronously mid-cycle.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[0]  = 64'h1C;
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (lat_of(0)) @(negedge clk);
      check("pre_reset err", 64'(resp_err[0]), 64'd1);
      #2 rst[0] = 1'b0;
      #1;
      check("async_reset req_ready", 64'(req_ready[0]), 64'd1);
      check("async_reset resp_valid", 64'(resp_valid[0]), 64'd0);
      check("async_reset rdata", resp_rdata[0], 64'd0);
      check("async_reset err", 64'(resp_err[0]), 64'd0);
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);

      for (int v = 0; v < N_VEC; v++) begin
         if (!vecs[v].poke) model_access(0, vecs[v].wr, vecs[v].addr, vecs[v].wd, m_rd, m_err);
         else               model_access(0, vecs[v].wr, vecs[v].addr, vecs[v].wd, m_rd, m_err);
         txn(0, vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].stall, vecs[v].poke,
             vecs[v].exp_rd, vecs[v].exp_err, $sformatf("vec%0d", v), acc);
      end

      // Reset during WAIT on the LATENCY=3 instance must drop the store.
      req_valid[1]  = 1'b1;
      req_write[1]  = 1'b1;
      req_addr[1]   = 64'h8;
      req_wdata[1]  = 64'h77;
      resp_ready[1] = 1'b1;
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      #2 rst[1] = 1'b0;
      #1;
      check("midtxn_reset req_ready", 64'(req_ready[1]), 64'd1);
      @(negedge clk);
      rst[1] = 1'b1;
      check("midtxn_release req_ready", 64'(req_ready[1]), 64'd1);
      check("midtxn_release resp_valid", 64'(resp_valid[1]), 64'd0);
      repeat (4) @(negedge clk);
      check("midtxn_no_resp", 64'(resp_valid[1]), 64'd0);
      txn(1, 1'b0, 64'h8, 64'h0, 0, 1'b0, 64'h0, 1'b0, "midtxn_load", acc);

      // Back-to-back stores on the LATENCY=1 instance: accept every 3 cycles.
      prev_acc = 0;
      for (int i = 0; i < 4; i++) begin
         model_access(2, 1'b1, 64'(i * 8), 64'(i + 1), m_rd, m_err);
         txn(2, 1'b1, 64'(i * 8), 64'(i + 1), 0, 1'b0, 64'h0, 1'b0, $sformatf("b2b_st%0d", i), acc);
         if (i > 0) check($sformatf("b2b_spacing%0d", i), 64'(acc - prev_acc), 64'd3);
         prev_acc = acc;
      end
      for (int i = 0; i < 4; i++) begin
         txn(2, 1'b0, 64'(i * 8), 64'h0, 0, 1'b0, 64'(i + 1), 1'b0, $sformatf("b2b_ld%0d", i), acc);
      end

      // Random traffic on instance 0 against the reference memory.
      for (int t = 0; t < 60; t++) begin
         int          r;
         int          idx;
         logic        wr;
         logic [63:0] wd;
         r   = int'($urandom_range(0, 9));
         idx = int'($urandom_range(0, DEPTH + 3));
         if (r == 0)      addr = {$urandom, $urandom};
         else if (r == 1) addr = 64'(idx * 8) + 64'($urandom_range(1, 7));
         else             addr = 64'(idx * 8);
         wr = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom};
         model_access(0, wr, addr, wd, m_rd, m_err);
         txn(0, wr, addr, wd, int'($urandom_range(0, 2)), 1'b0, m_rd, m_err,
             $sformatf("rnd%0d", t), acc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the LEGv8 datapath. It is the memory end of the CPU's load/store interface: it accepts one request at a time over a valid/ready handshake, waits a programmable number of cycles, performs a 64-bit doubleword read or write, and returns the result over a second valid/ready handshake. It replaces the zero-latency data memory wherever the CPU is wrapped with stall logic, and lets us model slow memory.

## Interface

**Parameters**
- `DEPTH`, default 32: number of 64-bit doublewords stored.
- `LATENCY`, default 2: cycles from request accept to response; legal range 1–15.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: the CPU presents a request.
- `req_ready`, out, 1: the responder can accept a request.
- `req_write`, in, 1: 1 = store (MemWrite), 0 = load (MemRead).
- `req_addr`, in, 64: byte address (the ALU result).
- `req_wdata`, in, 64: store data (ReadData2).
- `resp_valid`, out, 1: a response is presented.
- `resp_ready`, in, 1: the CPU consumes the response.
- `resp_rdata`, out, 64: load data; 0 for stores and errors.
- `resp_err`, out, 1: the request was misaligned or out of range.

## Operation

- **FSM states:** IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - At an edge with `req_valid` = 1, the request is accepted. `req_write`, `req_addr` and `req_wdata` are captured into internal registers, the counter is loaded with `LATENCY` − 1, and the FSM moves to WAIT.
- **WAIT**
  - If the counter ≠ 0, it decrements.
  - If the counter = 0, the access executes and the FSM moves to RESP.
  - `req_ready` = 0.
- **Access execution** (on the WAIT→RESP edge):
  - The index is `addr[63:3]`.
  - An error occurs if `addr[2:0]` ≠ 0 or the index ≥ `DEPTH`.
  - On error: memory is unchanged, `resp_rdata` = 0, `resp_err` = 1.
  - Store, no error: `mem[index]` ← wdata, `resp_rdata` = 0, `resp_err` = 0.
  - Load, no error: `resp_rdata` = `mem[index]`, `resp_err` = 0.
- **RESP**
  - `resp_valid` = 1. `resp_rdata` and `resp_err` are held stable until the handshake completes.
  - At an edge with `resp_ready` = 1, the FSM returns to IDLE.
  - `req_ready` = 0.
- **Blocked inputs:** requests arriving while not in IDLE are ignored and are never queued.
- **Ordering:** only one transaction is outstanding at a time. A load following a store to the same address returns the stored value.
- **Memory reset:** all `DEPTH` entries reset to 0.

## Timing

- **Reset values** (while `reset` = 0, applied immediately, asynchronously):
  - state = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, counter = 0.
  - All memory entries are 0.
- **Latency:** request accepted at edge E0; `resp_valid` rises after edge E0 + `LATENCY`. With `LATENCY` = 1, WAIT lasts exactly one cycle.
- **Earliest re-accept:** with `resp_ready` held at 1, `resp_valid` is high for one cycle. `req_ready` returns high after edge E0 + `LATENCY` + 1. The next request can be accepted at edge E0 + `LATENCY` + 2. Peak throughput is one transaction per `LATENCY` + 2 cycles.
- **Backpressure:** `resp_ready` = 0 stalls in RESP indefinitely with outputs constant.
- **Reset mid-transaction:** the transaction is aborted, and no memory write occurs if reset is asserted before the WAIT→RESP edge. After release, the block is in IDLE.
- **Address arithmetic:** the index comparison uses all 61 upper address bits. A huge address is an error; it never wraps to a small index.
- **Counter width:** 4 bits, which is sufficient for the maximum `LATENCY`.

## Test plan

1. **Reset.** Assert `reset` = 0 mid-cycle → outputs immediately read `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0. Then load from 0x0 → `resp_rdata` = 0.
2. **Store then load.** With `LATENCY` = 2: store 0xDEADBEEF_CAFEF00D to 0x18; `resp_valid` rises 2 edges after accept with `resp_err` = 0. Then load from 0x18 → `resp_rdata` = 0xDEADBEEF_CAFEF00D.
3. **Errors.** Load from 0x1C (misaligned) → `resp_err` = 1, `resp_rdata` = 0. Store 0x55 to 0x100 with `DEPTH` = 32 (index 32) → `resp_err` = 1. A subsequent load from 0x100 still gives `resp_err` = 1, and entry 0 is untouched (still 0).
4. **Backpressure.** Load from 0x18 with `resp_ready` = 0 for 5 cycles → `resp_valid` and `resp_rdata` are stable for all 5 cycles. During these cycles, `req_valid` = 1 with a store to 0x0 is ignored (`req_ready` = 0, mem[0] stays 0).
5. **Reset mid-transaction.** Store 0x77 to 0x8 with `LATENCY` = 3; assert reset during WAIT → then load from 0x8 → 0. Confirm the FSM is IDLE immediately after reset release.
6. **Back-to-back.** With `LATENCY` = 1 and `resp_ready` tied to 1: accept spacing is exactly 3 cycles across 4 consecutive stores to 0x0, 0x8, 0x10, 0x18 with values 1–4. Read-back returns 1, 2, 3, 4.
